// File: rtl/pulse_train_generator.sv
// Emits N pulses (H cycles high, L cycles low) per accepted command, then a one-cycle done strobe.
// The first pulse starts the cycle after the handshake; cmd_ready stays low until the train finishes or aborts.
module pulse_train_generator #(
  parameter int W_W   = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [W_W-1:0]   cmd_high,
  input  logic [W_W-1:0]   cmd_low,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             abort,
  output logic             a,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    FIN  = 2'd3
  } state_t;

  typedef struct packed {
    logic [W_W-1:0] high;
    logic [W_W-1:0] low;
  } lim_t;

  localparam logic [W_W-1:0]   ONE_W   = W_W'(1);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  state_t           state;
  state_t           state_nxt;
  lim_t             lim;
  logic [W_W-1:0]   phase_cnt;
  logic [CNT_W-1:0] rem_cnt;
  logic             accept;
  logic             phase_end;
  logic             a_nxt;
  logic             busy_nxt;
  logic             done_nxt;

  assign cmd_ready = (state == IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;

  // phase_cnt holds the 1-based cycle index within the current phase
  assign phase_end = (state == HIGH) ? (phase_cnt == lim.high) : (phase_cnt == lim.low);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      lim       <= '0;
      phase_cnt <= '0;
      rem_cnt   <= '0;
    end else begin
      state <= state_nxt;
      a     <= a_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;

      if (accept) begin
        lim.high <= (cmd_high == '0) ? ONE_W : cmd_high;
        lim.low  <= (cmd_low == '0) ? ONE_W : cmd_low;
        rem_cnt  <= cmd_count;
      end else if (state == HIGH && state_nxt == LOW) begin
        rem_cnt <= rem_cnt - ONE_CNT;
      end

      // Counting stops at the latched limit, so the counter never wraps
      if ((state_nxt == state) && (state == HIGH || state == LOW))
        phase_cnt <= phase_cnt + ONE_W;
      else
        phase_cnt <= ONE_W;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept)
          state_nxt = (cmd_count == '0) ? FIN : HIGH;
      end
      HIGH: begin
        if (abort)
          state_nxt = IDLE;
        else if (phase_end)
          state_nxt = LOW;
      end
      LOW: begin
        if (abort)
          state_nxt = IDLE;
        else if (phase_end)
          state_nxt = (rem_cnt == '0) ? FIN : HIGH;
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    a_nxt    = (state_nxt == HIGH);
    busy_nxt = (state_nxt == HIGH) || (state_nxt == LOW);
    done_nxt = (state_nxt == FIN);
  end

endmodule

// File: tb/tb_pulse_train_generator.sv
// Directed bench for pulse_train_generator: table of commands with hand-written a patterns,
// plus sequences for reset, abort, back-to-back commands and counter limits.
module tb_pulse_train_generator;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_high;
  logic [7:0] cmd_low;
  logic [7:0] cmd_count;
  logic       abort;
  logic       a;
  logic       busy;
  logic       done;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pulse_train_generator #(.W_W(8), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_high  (cmd_high),
    .cmd_low   (cmd_low),
    .cmd_count (cmd_count),
    .abort     (abort),
    .a         (a),
    .busy      (busy),
    .done      (done)
  );

  typedef struct {
    logic [7:0] h;
    logic [7:0] l;
    logic [7:0] n;
    string      a_exp;
    int         done_cyc;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic add_vec(input logic [7:0] h, input logic [7:0] l, input logic [7:0] n,
                         input string s, input int d);
    vec_t v;
    v.h = h;
    v.l = l;
    v.n = n;
    v.a_exp = s;
    v.done_cyc = d;
    vq.push_back(v);
  endtask

  // Called at a negedge; the following posedge is the handshake (cycle 0).
  task automatic start_cmd(input logic [7:0] h, input logic [7:0] l, input logic [7:0] n,
                           input logic ab);
    int w;
    w = 0;
    while (cmd_ready !== 1'b1 && w < 1000) begin
      @(negedge clk);
      w++;
    end
    chk("ready_before_cmd", 32'(cmd_ready), 32'd1);
    cmd_high  = h;
    cmd_low   = l;
    cmd_count = n;
    cmd_valid = 1'b1;
    abort     = ab;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    abort     = 1'b0;
    cmd_high  = 8'hA5;
    cmd_low   = 8'h5A;
    cmd_count = 8'hC3;
  endtask

  task automatic run_vec(input vec_t v);
    int   rises;
    int   len;
    logic prev;
    logic ea;
    string tag;
    rises = 0;
    prev  = 1'b0;
    len   = v.a_exp.len();
    start_cmd(v.h, v.l, v.n, 1'b0);
    for (int c = 1; c <= v.done_cyc + 1; c++) begin
      @(negedge clk);
      ea  = (c <= len) ? (v.a_exp[c-1] == "1") : 1'b0;
      tag = $sformatf("h%0d_l%0d_n%0d_c%0d", v.h, v.l, v.n, c);
      chk({"a_", tag}, 32'(a), 32'(ea));
      chk({"done_", tag}, 32'(done), 32'(c == v.done_cyc));
      chk({"busy_", tag}, 32'(busy), 32'((v.n != 0) && (c < v.done_cyc)));
      chk({"ready_", tag}, 32'(cmd_ready), 32'(c > v.done_cyc));
      if (a === 1'b1 && prev === 1'b0) rises++;
      prev = a;
    end
    chk($sformatf("rises_h%0d_l%0d_n%0d", v.h, v.l, v.n), 32'(rises), 32'(v.n));
  endtask

  task automatic measure(input logic [7:0] h, input logic [7:0] l, input logic [7:0] n,
                         input int maxc, output int hi, output int rises, output int dcyc);
    logic prev;
    prev  = 1'b0;
    hi    = 0;
    rises = 0;
    dcyc  = 0;
    start_cmd(h, l, n, 1'b0);
    for (int c = 1; c <= maxc; c++) begin
      @(negedge clk);
      if (a === 1'b1) hi++;
      if (a === 1'b1 && prev === 1'b0) rises++;
      if (done === 1'b1 && dcyc == 0) dcyc = c;
      prev = a;
    end
  endtask

  // Starts H=4 L=4 N=5, interrupts in cycle 3 with abort (use_rst=0) or rst (use_rst=1).
  task automatic interrupt_seq(input logic use_rst, input string nm);
    int dones;
    int highs;
    start_cmd(8'd4, 8'd4, 8'd5, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk($sformatf("%s_a_c%0d", nm, c), 32'(a), 32'd1);
    end
    if (use_rst) rst = 1'b1;
    else abort = 1'b1;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    chk({nm, "_a_c4"}, 32'(a), 32'd0);
    chk({nm, "_busy_c4"}, 32'(busy), 32'd0);
    chk({nm, "_done_c4"}, 32'(done), 32'd0);
    chk({nm, "_ready_c4"}, 32'(cmd_ready), 32'd1);
    dones = 0;
    highs = 0;
    for (int c = 5; c <= 50; c++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
      if (a === 1'b1 || busy === 1'b1) highs++;
    end
    chk({nm, "_late_done"}, 32'(dones), 32'd0);
    chk({nm, "_late_activity"}, 32'(highs), 32'd0);
  endtask

  initial begin
    int hi;
    int rises;
    int dcyc;

    add_vec(8'd1, 8'd1, 8'd3, "101010", 7);
    add_vec(8'd3, 8'd2, 8'd2, "1110011100", 11);
    add_vec(8'd0, 8'd0, 8'd2, "1010", 5);
    add_vec(8'd0, 8'd5, 8'd0, "", 1);
    add_vec(8'd2, 8'd1, 8'd3, "110110110", 10);
    add_vec(8'd1, 8'd3, 8'd2, "10001000", 9);

    rst       = 1'b1;
    cmd_valid = 1'b1;
    cmd_high  = 8'd1;
    cmd_low   = 8'd1;
    cmd_count = 8'd3;
    abort     = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("rst_a_%0d", i), 32'(a), 32'd0);
      chk($sformatf("rst_busy_%0d", i), 32'(busy), 32'd0);
      chk($sformatf("rst_done_%0d", i), 32'(done), 32'd0);
      chk($sformatf("rst_ready_%0d", i), 32'(cmd_ready), 32'd0);
    end
    rst       = 1'b0;
    cmd_valid = 1'b0;
    #1;
    chk("ready_after_rst", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    chk("no_accept_in_rst", 32'(busy), 32'd0);

    foreach (vq[i]) run_vec(vq[i]);

    measure(8'd255, 8'd1, 8'd1, 260, hi, rises, dcyc);
    chk("maxh_high_cycles", 32'(hi), 32'd255);
    chk("maxh_rises", 32'(rises), 32'd1);
    chk("maxh_done_cycle", 32'(dcyc), 32'd257);

    measure(8'd1, 8'd1, 8'd255, 515, hi, rises, dcyc);
    chk("maxn_high_cycles", 32'(hi), 32'd255);
    chk("maxn_rises", 32'(rises), 32'd255);
    chk("maxn_done_cycle", 32'(dcyc), 32'd511);

    interrupt_seq(1'b0, "abort");
    interrupt_seq(1'b1, "midrst");

    // abort coinciding with the handshake, and abort during FIN, are both ignored
    start_cmd(8'd1, 8'd1, 8'd1, 1'b1);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk($sformatf("abacc_a_c%0d", c), 32'(a), 32'(c == 1));
      chk($sformatf("abacc_done_c%0d", c), 32'(done), 32'(c == 3));
      abort = (c == 3);
    end
    abort = 1'b0;
    chk("abacc_ready_c4", 32'(cmd_ready), 32'd1);

    // cmd_valid held high: one-pulse commands accepted every fourth cycle
    cmd_high  = 8'd1;
    cmd_low   = 8'd1;
    cmd_count = 8'd1;
    cmd_valid = 1'b1;
    for (int c = 0; c < 16; c++) begin
      chk($sformatf("b2b_ready_c%0d", c), 32'(cmd_ready), 32'((c % 4) == 0));
      chk($sformatf("b2b_a_c%0d", c), 32'(a), 32'((c % 4) == 1));
      chk($sformatf("b2b_done_c%0d", c), 32'(done), 32'((c % 4) == 3));
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("b2b_idle_after", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pulse_train_generator.md
Name: pulse_train_generator

Overview:
- Sequential pulse-pattern source. It drives a single-bit line with programmable pulses of the kind that the posedge and one-cycle-pulse detectors consume.
- Accepts a command of high width, low gap and pulse count over a valid/ready handshake. It emits that many pulses, then signals completion.
- Used as a stimulus source in detector benches and as an on-chip strobe generator.

Parameters:
- W_W, 8, width of the high-width and low-gap command fields and their counters.
- CNT_W, 8, width of the pulse-count command field and its counter.

Ports:
- clk  input  1  clock; all logic updates on posedge clk.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  generator can accept a command.
- cmd_high  input  W_W  cycles each pulse is high; 0 is treated as 1.
- cmd_low  input  W_W  cycles of low gap after each pulse; 0 is treated as 1.
- cmd_count  input  CNT_W  number of pulses; 0 means no pulses.
- abort  input  1  stop the current train immediately.
- a  output  1  generated pulse line (registered).
- busy  output  1  train in progress.
- done  output  1  one-cycle completion strobe.

Behaviour:
- Reset (rst high at a posedge): state=IDLE, a=0, busy=0, done=0. All counters are cleared. Reset has priority over everything, including mid-train. After reset, cmd_ready=1 from the following cycle.
- cmd_ready is combinational and equals (state==IDLE && !rst). A command is accepted on a posedge where cmd_valid && cmd_ready. The fields are latched at that edge and later field changes are ignored.
- States:
  - IDLE: a=0, busy=0.
  - HIGH: a=1, busy=1.
  - LOW: a=0, busy=1.
  - FIN: a=0, busy=0, done=1, one cycle only.
- Effective values: H = max(cmd_high,1), L = max(cmd_low,1), N = cmd_count.
- Timing is counted from cycle 0, the cycle in which the handshake occurs.
  - Pulse k (k=0..N-1) drives a=1 in cycles k*(H+L)+1 .. k*(H+L)+H.
  - a=0 during the following L cycles.
  - The final pulse is also followed by its full L-cycle gap.
  - FIN occupies cycle N*(H+L)+1: done=1 and a=0 in that cycle.
  - IDLE (cmd_ready=1) resumes in cycle N*(H+L)+2.
- N=0: the command is accepted, a stays 0, FIN occurs in cycle 1, and cmd_ready=1 in cycle 2.
- Because L≥1, consecutive pulses are always separated by at least one low cycle. This holds across command boundaries too: FIN is low, so a new train never merges with the previous one.
- Transitions:
  - IDLE→HIGH on accept with N≥1.
  - IDLE→FIN on accept with N=0.
  - HIGH→LOW when the width counter reaches H.
  - LOW→HIGH when the gap counter reaches L and pulses remain.
  - LOW→FIN when the gap counter reaches L and the last pulse is done.
  - FIN→IDLE.
- Counters:
  - W_W-bit phase counter, reloaded on every phase entry.
  - CNT_W-bit remaining-pulse counter, decremented on each HIGH→LOW transition.
  - No wrap-around is possible: counters compare against latched limits and never count past them.
  - Maximum values H = 2^W_W−1 and N = 2^CNT_W−1 must work exactly.
- abort, sampled at a posedge while busy=1: the next state is IDLE, a=0 from the next cycle, and done is not asserted.
  - abort in IDLE or FIN has no effect. FIN still completes with done=1.
  - abort has no effect on a command being accepted in the same cycle.
  - rst has priority over abort.
- Outputs a, busy and done are registered. There are no combinational paths from inputs to a.

Test Plan:
- Reset: hold rst 2 cycles with cmd_valid=1 → a=0, busy=0, done=0, no command accepted. cmd_ready=1 the cycle after rst drops.
- Single pulses: H=1, L=1, N=3 → a over cycles 1..6 = 101010, done=1 in cycle 7, cmd_ready=1 in cycle 8. A one-cycle-pulse detector fed by a fires 3 times.
- Wide pulses: H=3, L=2, N=2 → a cycles 1..10 = 1110011100, done in cycle 11. A posedge detector fires exactly twice, in cycles 1 and 6.
- Zero fields: H=0, L=0, N=2 → treated as H=1, L=1: a = 1010, done in cycle 5. N=0 → a stays 0, done in cycle 1, ready in cycle 2.
- Abort and reset mid-train: H=4, L=4, N=5, abort in cycle 3 → a=0 from cycle 4, busy=0, no done, cmd_ready=1 in cycle 4. Repeat with rst instead of abort → same output, all outputs at reset values.
- Back-to-back and limits: keep cmd_valid=1 with H=1, L=1, N=1 → commands accepted every 4th cycle, a = 1,0,0,0 repeating with no merged pulses. Separately, H=255, N=1 → a high exactly 255 cycles.
